serv_dbus_resp: RTL and testbench
=================================

# serv_dbus_resp

Data-bus responder for the SERV core: the slave end of the Wishbone-classic dbus that the core drives with a word-aligned address, write data, byte selects, `we` and `cyc`. It decodes the word address, performs byte-lane writes or full-word reads into a local RAM, and returns a single-cycle `ack` after a programmable number of wait states. It sits between the core's dbus port and on-chip data memory in small SERV systems and test benches.

## Interface
- `DEPTH`, 256: RAM size in 32-bit words; power of two, ≥4. `AW = $clog2(DEPTH)`.
- `WAIT`, 0: wait states inserted before `ack`; range 0..15.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_dbus_adr`  in  32  byte address; bits [1:0] ignored.
- `i_dbus_dat`  in  32  write data.
- `i_dbus_sel`  in  4  byte-lane write enables; bit n covers bits [8n+7:8n].
- `i_dbus_we`  in  1  1 = write, 0 = read.
- `i_dbus_cyc`  in  1  transaction request; held high by the master until `ack`.
- `o_dbus_rdt`  out  32  read data; valid while `o_dbus_ack` = 1.
- `o_dbus_ack`  out  1  one-cycle completion strobe.
- `i_err_clr`  in  1  clears `o_err`.
- `o_err`  out  1  sticky out-of-range flag; tied 0 without `SERV_DBUS_RESP_ERR_EN`.

## Operation
- FSM states:
  - `IDLE`: if `cyc` = 1, latch `adr`, `dat`, `sel` and `we`; load the wait counter with `WAIT`; go to `WAIT` if `WAIT` > 0, otherwise go to `ACK`.
  - `WAIT`: decrement the counter; when it reaches 1, go to `ACK`.
  - `ACK`: `ack` = 1 for exactly one cycle; then go to `IDLE`.
- Word index = latched `adr[AW+1:2]`.
- Write:
  - Performed on the edge entering `ACK`.
  - Only lanes with `sel[n]` = 1 are updated.
  - `sel` = 0 is a legal no-op write and still acks.
- Read:
  - RAM is read on the edge entering `ACK`; the full word is returned regardless of `sel`.
  - `o_dbus_rdt` holds its value after `ack` until the next read completes.
  - Writes do not change `o_dbus_rdt`.
- `cyc` is ignored in `WAIT` and `ACK`. Mid-transaction changes of `adr`/`dat`/`sel`/`we` have no effect, since the latched copies are used.
- `cyc` still high in the cycle after `ack` is treated as a new transaction. This is legal: back-to-back transactions are accepted with no dead cycle.
- Reset values: state `IDLE`, `o_dbus_ack` 0, `o_dbus_rdt` 0, wait counter 0, `o_err` 0. RAM contents are not reset.
- Reset asserted mid-transaction: the transaction is abandoned; no write occurs unless the write edge coincides with the reset edge, in which case reset wins and nothing is written.

## Timing
- Latency, measured from the first `cyc`-high cycle sampled in `IDLE`: `ack` is high `WAIT`+1 cycles later. `WAIT` = 0 gives `ack` in the next cycle.
- Throughput with a master that keeps `cyc` high: one transaction every `WAIT`+2 cycles.
- A write is visible to a read accepted in the cycle after its `ack`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERV_DBUS_RESP_ERR_EN` defined:
  - An access is out-of-range when latched `adr[31:AW+2]` ≠ 0.
  - It still acks with normal timing.
  - A write is suppressed; a read returns 0.
  - `o_err` is set on the edge entering `ACK`.
  - `i_err_clr` clears `o_err`. If set and clear occur in the same cycle, set wins.
- `SERV_DBUS_RESP_ERR_EN` undefined: upper address bits are ignored (the RAM aliases), `o_err` = 0, and `i_err_clr` is unused.

## Structure
- Shared package `serv_dbus_pkg`:
  - State encoding `IDLE`=2'd0, `WAIT`=2'd1, `ACK`=2'd2.
  - `SERV_DBUS_WAIT_MAX` = 15.
- Sub-module `serv_dbus_ram`:
  - Byte-lane RAM with per-lane write enable, `DEPTH`×32.
  - Synchronous read; no reset on the array.
- The top level contains the FSM, wait counter, request latches and error logic.

## Test plan
- Basic, `WAIT`=0:
  - Write 0xDEADBEEF to 0x10 with `sel`=4'hF, then read 0x10 → `ack` 1 cycle after each `cyc`; `rdt` = 0xDEADBEEF.
  - Read 0x13 (low bits ignored) → `rdt` = 0xDEADBEEF.
- Byte lanes: write 0x000000AA with `sel`=4'b0001 over 0xDEADBEEF → read returns 0xDEADBEAA; write with `sel`=0 → the word is unchanged and `ack` still asserts.
- Wait states, `WAIT`=3: `ack` appears exactly 4 cycles after `cyc`; the first transaction is not repeated. With `cyc` held high for back-to-back transactions, acks are spaced 5 cycles apart.
- Mid-write reset, `WAIT`=2: assert `i_rst_n`=0 in the `WAIT` state → no `ack`; the word keeps its old value; `rdt` = 0; FSM in `IDLE`.
- Error, macro on, `DEPTH`=256: write to 0x400 → `ack`, `o_err`=1, word 0 is unchanged. A read of 0x400 returns 0. Asserting `i_err_clr` in the same cycle as a new error keeps `o_err`=1.
- Error, macro off: write to 0x400 → the write lands at word 0 (aliasing); `o_err` stays 0.

Source files
------------

// File: rtl/serv_dbus_pkg.sv
// -----------------------------------------------------------------------------
// serv_dbus_pkg
// Shared types and constants for the SERV data-bus responder.
//   dbus_state_e       : responder FSM state encoding
//   dbus_req_t         : one latched Wishbone-classic request
//   SERV_DBUS_WAIT_MAX : largest supported wait-state count
//   WCNT_W             : wait counter width
// -----------------------------------------------------------------------------
package serv_dbus_pkg;

  localparam int SERV_DBUS_WAIT_MAX = 15;
  localparam int WCNT_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dbus_state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } dbus_req_t;

  // Byte-lane write enables for a request that is allowed to write.
  function automatic logic [3:0] lane_we(input logic [3:0] sel, input logic en);
    return en ? sel : 4'b0000;
  endfunction

endpackage

// File: rtl/serv_dbus_ram.sv
// -----------------------------------------------------------------------------
// serv_dbus_ram
// DEPTH x 32 data RAM with per-byte-lane write enables and a synchronous,
// registered read port. The read register only updates when i_re is high,
// so it holds the last read word between reads.
// Ports:
//   i_clk      clock
//   i_rst_n    synchronous active-low reset (read register only)
//   i_we       byte-lane write enables
//   i_re       load the read register this edge
//   i_rd_zero  load zero instead of the addressed word (rejected reads)
//   i_addr     word address
//   i_wdata    write data
//   o_rdata    registered read data
// -----------------------------------------------------------------------------
module serv_dbus_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [3:0]    i_we,
  input  logic          i_re,
  input  logic          i_rd_zero,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rdata_d = rdata_q;
    if (i_re) rdata_d = i_rd_zero ? 32'd0 : mem[i_addr];
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!i_rst_n) rdata_q <= 32'd0;
    else          rdata_q <= rdata_d;
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge i_clk) begin
    for (int n = 0; n < 4; n++) begin
      if (i_we[n]) mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/serv_dbus_resp.sv
// -----------------------------------------------------------------------------
// serv_dbus_resp
// Wishbone-classic slave for the SERV dbus: latches a request, waits WAIT
// cycles, performs a byte-lane write or a full-word read on local RAM and
// returns a one-cycle ack. Back-to-back requests are accepted with no dead
// cycle after ack.
// Optional feature macro: SERV_DBUS_RESP_ERR_EN
//   defined   : addresses with adr[31:AW+2] != 0 are out of range; they ack
//               normally, writes are dropped, reads return 0, o_err is set.
//   undefined : upper address bits ignored (RAM aliases), o_err tied 0.
// Ports:
//   i_clk, i_rst_n (synchronous, active-low)
//   i_dbus_adr/dat/sel/we/cyc : request from the core
//   o_dbus_rdt, o_dbus_ack    : registered response
//   i_err_clr, o_err          : sticky out-of-range flag and its clear
// -----------------------------------------------------------------------------
module serv_dbus_resp
  import serv_dbus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic        i_err_clr,
  output logic        o_err
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_CNT = WCNT_W'(WAIT);

  dbus_state_e       state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  dbus_req_t         req_q, req_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  dbus_req_t         req_in;
  dbus_req_t         req_cur;
  logic              enter_ack;
  logic              oor;

  assign req_in = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we};

  // With WAIT = 0 the access happens on the same edge that accepts the
  // request, so the live bus must be used while still in IDLE.
  assign req_cur = (state_q == ST_IDLE) ? req_in : req_q;

`ifdef SERV_DBUS_RESP_ERR_EN
  assign oor = (req_cur.adr >> (AW + 2)) != 32'd0;
`else
  assign oor = 1'b0;
  wire unused_err = ^{i_err_clr, req_cur.adr[31:AW+2]};
`endif
  wire unused_adr_lo = ^req_cur.adr[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    enter_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_dbus_cyc) begin
          req_d = req_in;
          cnt_d = WAIT_CNT;
          if (WAIT_CNT != '0) begin
            state_d = ST_WAIT;
          end else begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WCNT_W'(1);
        if (cnt_q == WCNT_W'(1)) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ack_d = enter_ack;

`ifdef SERV_DBUS_RESP_ERR_EN
    // Set has priority over clear so an error is never lost.
    err_d = err_q;
    if (i_err_clr)        err_d = 1'b0;
    if (enter_ack && oor) err_d = 1'b1;
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // A write whose edge coincides with reset is dropped, hence the i_rst_n term.
  logic [3:0] ram_we;
  logic       ram_re;

  assign ram_we = lane_we(req_cur.sel, enter_ack && req_cur.we && !oor && i_rst_n);
  assign ram_re = enter_ack && !req_cur.we;

  serv_dbus_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (ram_we),
    .i_re      (ram_re),
    .i_rd_zero (oor),
    .i_addr    (req_cur.adr[AW+1:2]),
    .i_wdata   (req_cur.dat),
    .o_rdata   (o_dbus_rdt)
  );

  assign o_dbus_ack = ack_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_serv_dbus_resp.sv
// -----------------------------------------------------------------------------
// tb_serv_dbus_resp
// Three responders share one clock: instance 0 with WAIT=0, instance 1 with
// WAIT=3, instance 2 with WAIT=2. Directed transactions with hand-computed
// expected data and ack latencies.
// -----------------------------------------------------------------------------
module tb_serv_dbus_resp;

  logic        clk = 1'b0;
  logic        rst_n   [3];
  logic [31:0] adr     [3];
  logic [31:0] dat     [3];
  logic [3:0]  sel     [3];
  logic        we      [3];
  logic        cyc     [3];
  logic        err_clr [3];
  wire  [31:0] rdt     [3];
  wire         ack     [3];
  wire         err     [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serv_dbus_resp #(
      .DEPTH (256),
      .WAIT  (g == 0 ? 0 : (g == 1 ? 3 : 2))
    ) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n[g]),
      .i_dbus_adr (adr[g]),
      .i_dbus_dat (dat[g]),
      .i_dbus_sel (sel[g]),
      .i_dbus_we  (we[g]),
      .i_dbus_cyc (cyc[g]),
      .o_dbus_rdt (rdt[g]),
      .o_dbus_ack (ack[g]),
      .i_err_clr  (err_clr[g]),
      .o_err      (err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction; inputs are scrambled while waiting to show the latched
  // copy is used. Ends one cycle after ack with ack required low again.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, input logic w,
                     output logic [31:0] rd, output int lat);
    @(negedge clk);
    adr[d] = a; dat[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        lat = i;
        rd  = rdt[d];
        break;
      end
      adr[d] = a ^ 32'h40; dat[d] = ~wd; sel[d] = ~s; we[d] = ~w;
    end
    cyc[d] = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", {31'd0, ack[d]}, 32'd0);
  endtask

  task automatic do_wr(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input int exp_lat, input string tag);
    logic [31:0] rd;
    int          lat;
    txn(d, a, wd, s, 1'b1, rd, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_rd(input int d, input logic [31:0] a, input logic [31:0] exp,
                       input int exp_lat, input string tag);
    logic [31:0] rd;
    int          lat;
    txn(d, a, 32'hA5A5_5A5A, 4'h0, 1'b0, rd, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdt"}, rd, exp);
    check({tag, "_hold"}, rdt[d], exp);
  endtask

  initial begin
    int first_ack, second_ack, n_ack;

    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; adr[d] = '0; dat[d] = '0; sel[d] = '0;
      we[d] = 1'b0; cyc[d] = 1'b0; err_clr[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    // Reset state
    check("rst_ack", {31'd0, ack[0]}, 32'd0);
    check("rst_rdt", rdt[0], 32'd0);
    check("rst_err", {31'd0, err[0]}, 32'd0);

    // WAIT=0 basics
    do_wr(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, "w0_wr");
    do_rd(0, 32'h10, 32'hDEAD_BEEF, 1, "w0_rd");
    do_rd(0, 32'h13, 32'hDEAD_BEEF, 1, "w0_rd_lowbits");

    // Byte lanes
    do_wr(0, 32'h10, 32'h0000_00AA, 4'b0001, 1, "lane0_wr");
    check("wr_keeps_rdt", rdt[0], 32'hDEAD_BEEF);
    do_rd(0, 32'h10, 32'hDEAD_BEAA, 1, "lane0_rd");
    do_wr(0, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1, "sel0_wr");
    do_rd(0, 32'h10, 32'hDEAD_BEAA, 1, "sel0_rd");
    do_wr(0, 32'h10, 32'h1122_3344, 4'b1100, 1, "lane23_wr");
    do_rd(0, 32'h10, 32'h1122_BEAA, 1, "lane23_rd");

    // Out-of-range handling
    do_wr(0, 32'h0, 32'h0123_4567, 4'hF, 1, "w0_word0");
`ifdef SERV_DBUS_RESP_ERR_EN
    do_wr(0, 32'h400, 32'h55AA_55AA, 4'hF, 1, "oor_wr");
    check("oor_err_set", {31'd0, err[0]}, 32'd1);
    do_rd(0, 32'h0, 32'h0123_4567, 1, "oor_word0");
    do_rd(0, 32'h400, 32'h0, 1, "oor_rd");
    check("oor_err_sticky", {31'd0, err[0]}, 32'd1);
    @(negedge clk); err_clr[0] = 1'b1;
    @(posedge clk); #1; err_clr[0] = 1'b0;
    check("err_clr", {31'd0, err[0]}, 32'd0);
    err_clr[0] = 1'b1;
    do_wr(0, 32'h404, 32'h0, 4'hF, 1, "oor_set_clr");
    err_clr[0] = 1'b0;
    check("set_beats_clr", {31'd0, err[0]}, 32'd1);
`else
    do_wr(0, 32'h400, 32'h55AA_55AA, 4'hF, 1, "alias_wr");
    check("alias_err", {31'd0, err[0]}, 32'd0);
    do_rd(0, 32'h0, 32'h55AA_55AA, 1, "alias_rd");
`endif

    // WAIT=3: latency 4, no repeat, latched request used
    do_wr(1, 32'h40, 32'h1234_5678, 4'hF, 4, "w3_wr");
    n_ack = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1]) n_ack++;
    end
    check("w3_no_repeat", 32'(n_ack), 32'd0);
    do_rd(1, 32'h40, 32'h1234_5678, 4, "w3_rd");

    // WAIT=3: back-to-back reads with cyc held high
    @(negedge clk);
    adr[1] = 32'h40; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1;
    first_ack = 0; second_ack = 0; n_ack = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ack[1]) begin
        n_ack++;
        if (n_ack == 1) first_ack = i;
        if (n_ack == 2) second_ack = i;
      end
    end
    cyc[1] = 1'b0;
    check("b2b_first", 32'(first_ack), 32'd4);
    check("b2b_second", 32'(second_ack), 32'd9);
    check("b2b_count", 32'(n_ack), 32'd2);
    check("b2b_rdt", rdt[1], 32'h1234_5678);

    // WAIT=2: reset during WAIT abandons the write
    do_wr(2, 32'h20, 32'h1111_1111, 4'hF, 3, "w2_wr");
    do_rd(2, 32'h20, 32'h1111_1111, 3, "w2_rd");
    @(negedge clk);
    adr[2] = 32'h20; dat[2] = 32'h2222_2222; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
    @(posedge clk); #1;
    rst_n[2] = 1'b0; cyc[2] = 1'b0;
    n_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack[2]) n_ack++;
    end
    check("rst_mid_noack", 32'(n_ack), 32'd0);
    check("rst_mid_rdt", rdt[2], 32'd0);
    rst_n[2] = 1'b1;
    do_rd(2, 32'h20, 32'h1111_1111, 3, "rst_mid_keep");

    // WAIT=2: reset on the very edge that would perform the write
    @(negedge clk);
    adr[2] = 32'h20; dat[2] = 32'h3333_3333; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b0; cyc[2] = 1'b0;
    @(posedge clk); #1;
    check("rst_edge_noack", {31'd0, ack[2]}, 32'd0);
    rst_n[2] = 1'b1;
    do_rd(2, 32'h20, 32'h1111_1111, 3, "rst_edge_keep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
